// File: rtl/line_window_column.sv
// Vertical window column builder: keeps WIN_H-1 past lines in circular line memories and
// emits one WIN_H-tall column per accepted pixel. Optional top-border zeroing: LINEWIN_BORDER_MASK_EN.
module line_window_column #(
   parameter int N     = 8,
   parameter int WIN_H = 5,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int XW    = $clog2(IMG_W),
   parameter int YW    = $clog2(IMG_H)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       i_pix,
   input  logic               i_valid,
   input  logic               i_sof,
   output logic [WIN_H*N-1:0] o_col,
   output logic               o_valid,
   output logic [XW-1:0]      o_x,
   output logic [YW-1:0]      o_y,
   output logic               o_rows_ok,
   output logic               o_sof,
   output logic               o_eof,
   output logic               o_frame_err
);

   // state | meaning
   // IDLE  | waiting for i_valid & i_sof; other pixels are dropped
   // FILL  | accepting lines 0..WIN_H-2, upper rows not yet real data
   // RUN   | all rows valid until pixel (IMG_W-1, IMG_H-1) is accepted

   localparam int M  = WIN_H - 1;
   localparam int LW = (M > 1) ? $clog2(M) : 1;
   localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
   localparam logic [YW-1:0] Y_RUN   = YW'(WIN_H - 1);
   localparam logic [LW-1:0] LP_LAST = LW'(M - 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [XW-1:0]     x_q, x_d, cur_x;
   logic [YW-1:0]     y_q, y_d, cur_y;
   logic [LW-1:0]     lp_q, lp_d;
   logic              accept, restart, eol, eof, ferr;
   logic [N-1:0]      mem [0:M-1][0:IMG_W-1];
   logic [N-1:0]      rd [0:M-1];
   logic [WIN_H*N-1:0] col_d;

   // Memory written k lines ago sits k slots behind the line pointer.
   function automatic logic [LW-1:0] row_sel(input logic [LW-1:0] lp, input int k);
      int t;
      t = (int'(lp) + M - k) % M;
      return LW'(t);
   endfunction

   always_comb begin
      accept  = i_valid && (i_sof || (state_q != S_IDLE));
      restart = accept && i_sof;
      ferr    = restart && (state_q != S_IDLE);
      cur_x   = i_sof ? '0 : x_q;
      cur_y   = i_sof ? '0 : y_q;
      eol     = (cur_x == X_LAST);
      eof     = accept && eol && (cur_y == Y_LAST);
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      lp_d    = lp_q;
      if (accept) begin
         x_d = eol ? '0 : cur_x + XW'(1);
         y_d = cur_y;
         if (eol) begin
            y_d  = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
            lp_d = (lp_q == LP_LAST) ? '0 : lp_q + LW'(1);
         end
         if (eof)
            state_d = S_IDLE;
         else if (y_d >= Y_RUN)
            state_d = S_RUN;
         else
            state_d = S_FILL;
      end
   end

   always_comb begin
      for (int m = 0; m < M; m++)
         rd[m] = mem[m][cur_x];
   end

   always_comb begin
      col_d        = '0;
      col_d[N-1:0] = i_pix;
      for (int k = 1; k < WIN_H; k++) begin
         col_d[k*N +: N] = rd[row_sel(lp_q, k)];
`ifdef LINEWIN_BORDER_MASK_EN
         if (k > int'(cur_y))
            col_d[k*N +: N] = '0;
`endif
      end
   end

   // Read above happens combinationally on the old contents, so this write is read-before-write.
   always_ff @(posedge clk) begin
      if (accept)
         mem[lp_q][cur_x] <= i_pix;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         lp_q    <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         lp_q    <= lp_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_col       <= '0;
         o_valid     <= 1'b0;
         o_x         <= '0;
         o_y         <= '0;
         o_rows_ok   <= 1'b0;
         o_sof       <= 1'b0;
         o_eof       <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_valid     <= accept;
         o_sof       <= restart;
         o_eof       <= eof;
         o_frame_err <= ferr;
         if (accept) begin
            o_col     <= col_d;
            o_x       <= cur_x;
            o_y       <= cur_y;
            o_rows_ok <= (cur_y >= Y_RUN);
         end
      end
   end

endmodule

// File: tb/tb_line_window_column.sv
// Directed bench for line_window_column on a 4x4 image with a 3-line window.
// Honors LINEWIN_BORDER_MASK_EN for the expected top-border rows.
module tb_line_window_column;
   localparam int N = 8, WIN_H = 3, IMG_W = 4, IMG_H = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  i_pix;
   logic        i_valid, i_sof;
   logic [23:0] o_col;
   logic        o_valid;
   logic [1:0]  o_x, o_y;
   logic        o_rows_ok, o_sof, o_eof, o_frame_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   line_window_column #(.N(N), .WIN_H(WIN_H), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk(clk), .rst_n(rst_n), .i_pix(i_pix), .i_valid(i_valid), .i_sof(i_sof),
      .o_col(o_col), .o_valid(o_valid), .o_x(o_x), .o_y(o_y), .o_rows_ok(o_rows_ok),
      .o_sof(o_sof), .o_eof(o_eof), .o_frame_err(o_frame_err));

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic v, input logic s, input logic [7:0] p);
      @(negedge clk);
      i_valid = v;
      i_sof   = s;
      i_pix   = p;
      @(posedge clk);
      #1;
   endtask

   // Row k of the column is line y-k; above the top it is zero (mask) or previous-frame data.
   task automatic exp_col(input int x, input int y, input bit prev_ok,
                          output logic [23:0] val, output logic [23:0] care);
      val  = '0;
      care = '0;
      for (int k = 0; k < WIN_H; k++) begin
         if (y >= k) begin
            val[k*8 +: 8]  = 8'((y - k) * 16 + x);
            care[k*8 +: 8] = 8'hff;
         end else begin
`ifdef LINEWIN_BORDER_MASK_EN
            care[k*8 +: 8] = 8'hff;
`else
            if (prev_ok) begin
               val[k*8 +: 8]  = 8'((IMG_H + y - k) * 16 + x);
               care[k*8 +: 8] = 8'hff;
            end
`endif
         end
      end
   endtask

   task automatic chk_pix(input int x, input int y, input bit sof, input bit eof,
                          input bit ferr, input bit prev_ok);
      logic [23:0] v, c;
      exp_col(x, y, prev_ok, v, c);
      chk("o_valid", 32'(o_valid), 32'(1));
      chk("o_x", 32'(o_x), 32'(x));
      chk("o_y", 32'(o_y), 32'(y));
      chk("o_sof", 32'(o_sof), 32'(sof));
      chk("o_eof", 32'(o_eof), 32'(eof));
      chk("o_frame_err", 32'(o_frame_err), 32'(ferr));
      chk("o_rows_ok", 32'(o_rows_ok), 32'(y >= WIN_H - 1));
      chk("o_col", 32'(o_col & c), 32'(v));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_col"}, 32'(o_col), 32'(0));
      chk({tag, "_valid"}, 32'(o_valid), 32'(0));
      chk({tag, "_x"}, 32'(o_x), 32'(0));
      chk({tag, "_y"}, 32'(o_y), 32'(0));
      chk({tag, "_rows_ok"}, 32'(o_rows_ok), 32'(0));
      chk({tag, "_sof"}, 32'(o_sof), 32'(0));
      chk({tag, "_eof"}, 32'(o_eof), 32'(0));
      chk({tag, "_ferr"}, 32'(o_frame_err), 32'(0));
   endtask

   task automatic frame(input bit toggle, input bit prev_ok);
      logic [23:0] v, c;
      for (int y = 0; y < IMG_H; y++) begin
         for (int x = 0; x < IMG_W; x++) begin
            step(1'b1, (x == 0 && y == 0), 8'(y * 16 + x));
            chk_pix(x, y, (x == 0 && y == 0), (x == IMG_W-1 && y == IMG_H-1), 1'b0, prev_ok);
            if (toggle) begin
               step(1'b0, 1'b0, 8'hee);
               exp_col(x, y, prev_ok, v, c);
               chk("gap_valid", 32'(o_valid), 32'(0));
               chk("gap_sof", 32'(o_sof), 32'(0));
               chk("gap_eof", 32'(o_eof), 32'(0));
               chk("gap_col_hold", 32'(o_col & c), 32'(v));
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_pix = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // pixels without sof in IDLE are dropped
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 8'h55);
         chk("idle_drop", 32'(o_valid), 32'(0));
      end

      // first frame, then a back-to-back second frame, then a gapped third frame
      frame(1'b0, 1'b0);
      frame(1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00);
      chk("end_valid", 32'(o_valid), 32'(0));
      chk("end_eof", 32'(o_eof), 32'(0));
      chk("end_col_hold", 32'(o_col), 32'(24'h132333));
      frame(1'b1, 1'b1);

      // sof on the 6th pixel of a frame
      for (int i = 0; i < 5; i++) begin
         step(1'b1, (i == 0), 8'((i / IMG_W) * 16 + (i % IMG_W)));
         chk_pix(i % IMG_W, i / IMG_W, (i == 0), 1'b0, 1'b0, 1'b1);
      end
      step(1'b1, 1'b1, 8'h00);
      chk_pix(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);

      // sof coincident with the final pixel restarts instead of ending the frame
      for (int y = 0; y < IMG_H; y++) begin
         for (int x = 0; x < IMG_W; x++) begin
            if (x == 0 && y == 0) continue;
            if (x == IMG_W-1 && y == IMG_H-1) begin
               step(1'b1, 1'b1, 8'h00);
               chk_pix(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
            end else begin
               step(1'b1, 1'b0, 8'(y * 16 + x));
               chk_pix(x, y, 1'b0, 1'b0, 1'b0, 1'b0);
            end
         end
      end

      // run to (1,1), then reset while the frame is in flight
      for (int i = 1; i < 6; i++) begin
         step(1'b1, 1'b0, 8'((i / IMG_W) * 16 + (i % IMG_W)));
         chk_pix(i % IMG_W, i / IMG_W, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      i_valid = 1'b0;
      rst_n   = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 8'h12);
      chk("post_rst_drop", 32'(o_valid), 32'(0));
      frame(1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
